// File: rtl/lcd_pkg.sv
// Shared definitions for the SPI LCD panel receiver.
// Holds the receiver state encoding, the panel command opcodes recognised by
// the optional command decoder, and the default reset/boot timing constants
// (36 MHz CLK: 360 cycles = 10 us minimum reset pulse, 2^20 cycles boot).
package lcd_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    BOOT_WAIT  = 2'd1,
    READY      = 2'd2
  } lcd_state_t;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;

  localparam int unsigned LCD_MIN_RST_CYC = 360;
  localparam int unsigned LCD_BOOT_CYC    = 1048576;

endpackage

// File: rtl/lcd_sync_edge.sv
// Two-flop synchronizer for one asynchronous panel pin, with an optional
// rising-edge detect taken from the second stage against a third register.
// Ports:
//   CLK   system clock
//   RST   synchronous active-low reset; all stages load INIT
//   d     asynchronous pin
//   q     synchronized level (stage 2)
//   rise  one-cycle pulse on a synchronized 0->1 transition (0 when EDGE_EN=0)
module lcd_sync_edge #(
  parameter logic INIT    = 1'b0,
  parameter bit   EDGE_EN = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1;
  logic s2;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1 <= INIT;
      s2 <= INIT;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  generate
    if (EDGE_EN) begin : g_edge
      logic s3;
      always_ff @(posedge CLK) begin
        if (!RST) s3 <= INIT;
        else      s3 <= s2;
      end
      assign rise = s2 & ~s3;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/lcd_spi_rx.sv
// Panel-side receiver for a 4-wire SPI LCD link (SCK, SDA, DC, CS + RSTN).
// Synchronizes the pins into CLK, deserializes MSB-first bytes tagged with
// DC, enforces the panel reset / boot window and hands bytes downstream via
// a one-deep valid/ready output register.
// Optional feature macro: LCD_RX_CMD_DECODE_EN -- decodes command bytes
// (SWRESET, SLPIN/SLPOUT, DISPOFF/DISPON) and adds the SLEEP/DISP_ON ports.
// Ports:
//   CLK, RST               clock; synchronous active-low block reset
//   LCD_SCK/SDA/DC/CS/RSTN asynchronous panel pins (CS, RSTN active-low)
//   BYTE, BYTE_DC          received byte and its DC tag (0 cmd, 1 data)
//   BYTE_VALID/BYTE_READY  output handshake
//   OVERRUN                sticky: a completed byte was lost to backpressure
//   BUSY                   high whenever not in READY
//   PANEL_RESET            one-cycle pulse when a panel reset is accepted
//   SLEEP, DISP_ON         panel status (decode build only)
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int unsigned MIN_RST_CYC = LCD_MIN_RST_CYC,
  parameter int unsigned BOOT_CYC    = LCD_BOOT_CYC
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LCD_SCK,
  input  logic       LCD_SDA,
  input  logic       LCD_DC,
  input  logic       LCD_CS,
  input  logic       LCD_RSTN,
  output logic [7:0] BYTE,
  output logic       BYTE_DC,
  output logic       BYTE_VALID,
  input  logic       BYTE_READY,
  output logic       OVERRUN,
  output logic       BUSY,
`ifdef LCD_RX_CMD_DECODE_EN
  output logic       SLEEP,
  output logic       DISP_ON,
`endif
  output logic       PANEL_RESET
);

  localparam int BOOT_W = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
  localparam int LOW_W  = (MIN_RST_CYC > 0) ? $clog2(MIN_RST_CYC + 1) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYC - 1);
  localparam logic [LOW_W-1:0]  LOW_MAX   = LOW_W'(MIN_RST_CYC);

  lcd_state_t        state, state_nxt, saved_state;
  logic [BOOT_W-1:0] boot_cnt;
  logic [LOW_W-1:0]  low_cnt;
  logic [2:0]        bit_cnt;
  logic [6:0]        shifter;

  logic sck_rise, sda_s, dc_s, cs_s, rstn_s;
  logic unused_sck_q, unused_sda_rise, unused_dc_rise, unused_cs_rise, unused_rstn_rise;

  logic       shift_evt, byte_done, load, lost, accept, swreset;
  logic [7:0] new_byte;
  logic       pr_nxt, boot_inc, boot_clr, low_start;

  // Pin synchronizers; CS and RSTN idle high so they reset to 1
  lcd_sync_edge #(.INIT(1'b0), .EDGE_EN(1'b1)) u_sync_sck (
    .CLK(CLK), .RST(RST), .d(LCD_SCK), .q(unused_sck_q), .rise(sck_rise));
  lcd_sync_edge #(.INIT(1'b0), .EDGE_EN(1'b0)) u_sync_sda (
    .CLK(CLK), .RST(RST), .d(LCD_SDA), .q(sda_s), .rise(unused_sda_rise));
  lcd_sync_edge #(.INIT(1'b0), .EDGE_EN(1'b0)) u_sync_dc (
    .CLK(CLK), .RST(RST), .d(LCD_DC), .q(dc_s), .rise(unused_dc_rise));
  lcd_sync_edge #(.INIT(1'b1), .EDGE_EN(1'b0)) u_sync_cs (
    .CLK(CLK), .RST(RST), .d(LCD_CS), .q(cs_s), .rise(unused_cs_rise));
  lcd_sync_edge #(.INIT(1'b1), .EDGE_EN(1'b0)) u_sync_rstn (
    .CLK(CLK), .RST(RST), .d(LCD_RSTN), .q(rstn_s), .rise(unused_rstn_rise));

  // Shift/byte completion, and output register handshake decisions
  assign shift_evt = (state == READY) && rstn_s && !cs_s && sck_rise;
  assign byte_done = shift_evt && (bit_cnt == 3'd7);
  assign new_byte  = {shifter, sda_s};
  assign accept    = BYTE_VALID && BYTE_READY;
  // A byte completing while the consumer is taking the old one still loads
  assign load      = byte_done && (!BYTE_VALID || BYTE_READY);
  assign lost      = byte_done && BYTE_VALID && !BYTE_READY;

`ifdef LCD_RX_CMD_DECODE_EN
  assign swreset = load && !dc_s && (new_byte == CMD_SWRESET);
`else
  assign swreset = 1'b0;
`endif

  assign BUSY = (state != READY);

  always_ff @(posedge CLK) begin
    if (!RST) state <= BOOT_WAIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pr_nxt    = 1'b0;
    boot_inc  = 1'b0;
    boot_clr  = 1'b0;
    low_start = 1'b0;
    if (!rstn_s) begin
      state_nxt = RESET_HOLD;
      low_start = (state != RESET_HOLD);
    end else begin
      case (state)
        RESET_HOLD: begin
          if (low_cnt >= LOW_MAX) begin
            pr_nxt    = 1'b1;
            boot_clr  = 1'b1;
            state_nxt = BOOT_WAIT;
          end else begin
            // Too short: a glitch, resume whatever was interrupted
            state_nxt = saved_state;
          end
        end
        BOOT_WAIT: begin
          if (boot_cnt == BOOT_LAST) state_nxt = READY;
          else                       boot_inc  = 1'b1;
        end
        READY: begin
          if (swreset) begin
            boot_clr  = 1'b1;
            state_nxt = BOOT_WAIT;
          end
        end
        default: state_nxt = BOOT_WAIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      saved_state <= BOOT_WAIT;
      boot_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      BYTE        <= '0;
      BYTE_DC     <= 1'b0;
      BYTE_VALID  <= 1'b0;
      OVERRUN     <= 1'b0;
      PANEL_RESET <= 1'b0;
    end else begin
      PANEL_RESET <= pr_nxt;

      if (low_start) begin
        saved_state <= state;
        low_cnt     <= LOW_W'(1);
      end else if (!rstn_s && (low_cnt != LOW_MAX)) begin
        low_cnt <= low_cnt + LOW_W'(1);
      end

      // Boot count is frozen while a reset pulse is being qualified
      if (boot_clr)      boot_cnt <= '0;
      else if (boot_inc) boot_cnt <= boot_cnt + BOOT_W'(1);

      if (!rstn_s || cs_s || (state != READY)) bit_cnt <= '0;
      else if (sck_rise)                       bit_cnt <= bit_cnt + 3'd1;

      if (!rstn_s)     BYTE_VALID <= 1'b0;
      else if (load)   BYTE_VALID <= 1'b1;
      else if (accept) BYTE_VALID <= 1'b0;

      if (load) begin
        BYTE    <= new_byte;
        BYTE_DC <= dc_s;
      end

      if (lost) OVERRUN <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rstn_s)        shifter <= '0;
    else if (shift_evt) shifter <= new_byte[6:0];
  end

`ifdef LCD_RX_CMD_DECODE_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      SLEEP   <= 1'b1;
      DISP_ON <= 1'b0;
    end else if (pr_nxt || swreset) begin
      SLEEP   <= 1'b1;
      DISP_ON <= 1'b0;
    end else if (load && !dc_s) begin
      case (new_byte)
        CMD_SLPIN:   SLEEP   <= 1'b1;
        CMD_SLPOUT:  SLEEP   <= 1'b0;
        CMD_DISPOFF: DISP_ON <= 1'b0;
        CMD_DISPON:  DISP_ON <= 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Self-checking bench for lcd_spi_rx (MIN_RST_CYC=4, BOOT_CYC=16).
// Table-driven byte vectors, hand-written reset/backpressure sequences and a
// randomized stream checked against a queue-based reference model.
module tb_lcd_spi_rx;

  logic       CLK;
  logic       RST;
  logic       LCD_SCK, LCD_SDA, LCD_DC, LCD_CS, LCD_RSTN;
  logic [7:0] BYTE;
  logic       BYTE_DC, BYTE_VALID, BYTE_READY;
  logic       OVERRUN, BUSY, PANEL_RESET;
`ifdef LCD_RX_CMD_DECODE_EN
  logic       SLEEP, DISP_ON;
`endif

  lcd_spi_rx #(.MIN_RST_CYC(4), .BOOT_CYC(16)) dut (
    .CLK(CLK), .RST(RST),
    .LCD_SCK(LCD_SCK), .LCD_SDA(LCD_SDA), .LCD_DC(LCD_DC),
    .LCD_CS(LCD_CS), .LCD_RSTN(LCD_RSTN),
    .BYTE(BYTE), .BYTE_DC(BYTE_DC), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .OVERRUN(OVERRUN), .BUSY(BUSY),
`ifdef LCD_RX_CMD_DECODE_EN
    .SLEEP(SLEEP), .DISP_ON(DISP_ON),
`endif
    .PANEL_RESET(PANEL_RESET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_ready = 1'b0;
  logic [8:0] got_q[$];

  // Transfer monitor: samples mid-low-phase, after the stimulus has settled
  always begin
    @(negedge CLK);
    #3;
    if (BYTE_VALID && BYTE_READY) got_q.push_back({BYTE_DC, BYTE});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
    if (rand_ready) BYTE_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic spi_bit(input logic b, input logic dc, input int hp, input bit tchk);
    LCD_SCK = 1'b0;
    LCD_SDA = b;
    LCD_DC  = dc;
    repeat (hp) step();
    LCD_SCK = 1'b1;
    if (tchk) begin
      step(); check("valid_lat_k1", BYTE_VALID, 0);
      step(); check("valid_lat_k2", BYTE_VALID, 0);
      step(); check("valid_lat_k3", BYTE_VALID, 1);
    end else begin
      repeat (hp) step();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc, input int nbits,
                           input int hp, input bit tchk);
    LCD_CS = 1'b0;
    for (int i = 0; i < nbits; i++) spi_bit(b[7-i], dc, hp, tchk && (i == nbits - 1));
    LCD_SCK = 1'b0;
    repeat (2) step();
    LCD_CS = 1'b1;
    repeat (2) step();
  endtask

  task automatic reset_dut();
    RST = 1'b0;
    step(); step();
    RST = 1'b1;
    repeat (18) step();
  endtask

  typedef struct {
    logic [7:0] b;
    logic       dc;
    logic [7:0] exp_b;
    logic       exp_dc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [8:0] item;
    logic [7:0] rb;
    logic       rdc;
    int         hp;
    int         exp_cnt;
    bit         pr_seen;
    logic [8:0] exp_q[$];

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[1] = '{8'h2A, 1'b0, 8'h2A, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 8'h01, 1'b1};

    RST = 1'b0; LCD_SCK = 1'b0; LCD_SDA = 1'b0; LCD_DC = 1'b0;
    LCD_CS = 1'b1; LCD_RSTN = 1'b1; BYTE_READY = 1'b1;

    // Reset and boot window
    step(); step();
    RST = 1'b1;
    check("rst_valid", BYTE_VALID, 0);
    check("rst_overrun", OVERRUN, 0);
    check("rst_panel_reset", PANEL_RESET, 0);
    check("rst_byte", BYTE, 8'h00);
`ifdef LCD_RX_CMD_DECODE_EN
    check("rst_sleep", SLEEP, 1);
    check("rst_disp_on", DISP_ON, 0);
`endif
    for (int i = 0; i < 16; i++) begin
      check("boot_busy", BUSY, 1);
      step();
    end
    check("boot_done_busy", BUSY, 0);

    // Table of bytes with ready consumer, including VALID latency
    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      send_byte(vecs[i].b, vecs[i].dc, 8, 2, 1'b1);
      check("tbl_count", got_q.size(), 1);
      if (got_q.size() > 0) begin
        item = got_q.pop_front();
        check("tbl_byte", item[7:0], vecs[i].exp_b);
        check("tbl_dc", item[8], vecs[i].exp_dc);
      end
    end

    // Backpressure overrun: old byte kept, new byte dropped
    got_q.delete();
    BYTE_READY = 1'b0;
    send_byte(8'h11, 1'b1, 8, 2, 1'b0);
    send_byte(8'h22, 1'b1, 8, 2, 1'b0);
    check("ovr_byte", BYTE, 8'h11);
    check("ovr_valid", BYTE_VALID, 1);
    check("ovr_flag", OVERRUN, 1);
    check("ovr_no_xfer", got_q.size(), 0);
    BYTE_READY = 1'b1;
    repeat (4) step();
    check("ovr_xfer_count", got_q.size(), 1);
    if (got_q.size() > 0) check("ovr_xfer_byte", got_q.pop_front(), 9'h111);
    check("ovr_valid_clr", BYTE_VALID, 0);
    check("ovr_sticky", OVERRUN, 1);

    reset_dut();
    check("rst2_overrun", OVERRUN, 0);
    check("rst2_busy", BUSY, 0);

    // CS abort after 5 bits
    got_q.delete();
    send_byte(8'hF0, 1'b1, 5, 2, 1'b0);
    send_byte(8'h3C, 1'b0, 8, 2, 1'b0);
    check("abort_count", got_q.size(), 1);
    if (got_q.size() > 0) check("abort_byte", got_q.pop_front(), 9'h03C);

`ifdef LCD_RX_CMD_DECODE_EN
    got_q.delete();
    check("dec_sleep0", SLEEP, 1);
    send_byte(8'h11, 1'b0, 8, 2, 1'b0);
    check("dec_slpout", SLEEP, 0);
    send_byte(8'h29, 1'b0, 8, 2, 1'b0);
    check("dec_dispon", DISP_ON, 1);
    send_byte(8'h01, 1'b0, 8, 2, 1'b0);
    check("dec_swreset_busy", BUSY, 1);
    check("dec_swreset_sleep", SLEEP, 1);
    check("dec_swreset_disp", DISP_ON, 0);
    check("dec_count", got_q.size(), 3);
    repeat (20) step();
    check("dec_reboot_busy", BUSY, 0);
`else
    got_q.delete();
    send_byte(8'h01, 1'b0, 8, 2, 1'b0);
    check("swreset_plain_busy", BUSY, 0);
    check("swreset_plain_count", got_q.size(), 1);
    if (got_q.size() > 0) check("swreset_plain_byte", got_q.pop_front(), 9'h001);
`endif

    // RSTN glitch mid-byte: ignored, partial byte discarded
    got_q.delete();
    LCD_CS = 1'b0;
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, 2, 1'b0);
    LCD_SCK = 1'b0;
    step();
    LCD_RSTN = 1'b0;
    step(); step();
    LCD_RSTN = 1'b1;
    pr_seen = 1'b0;
    repeat (6) begin
      step();
      if (PANEL_RESET) pr_seen = 1'b1;
    end
    check("glitch_no_pr", pr_seen, 0);
    check("glitch_busy", BUSY, 0);
    rb = 8'h5A;
    for (int i = 0; i < 8; i++) spi_bit(rb[7-i], 1'b0, 2, 1'b0);
    LCD_SCK = 1'b0;
    repeat (2) step();
    LCD_CS = 1'b1;
    repeat (2) step();
    check("glitch_count", got_q.size(), 1);
    if (got_q.size() > 0) check("glitch_byte", got_q.pop_front(), 9'h05A);

    // Accepted panel reset: pending byte discarded, bytes dropped, boot window
    got_q.delete();
    BYTE_READY = 1'b0;
    send_byte(8'h99, 1'b1, 8, 2, 1'b0);
    check("prst_pending", BYTE_VALID, 1);
    LCD_RSTN = 1'b0;
    repeat (3) step();
    check("prst_valid_clr", BYTE_VALID, 0);
    check("prst_hold_busy", BUSY, 1);
    BYTE_READY = 1'b1;
    send_byte(8'h77, 1'b1, 8, 2, 1'b0);
    LCD_RSTN = 1'b1;
    step(); check("prst_k1", PANEL_RESET, 0);
    step(); check("prst_k2", PANEL_RESET, 0);
    step(); check("prst_k3", PANEL_RESET, 1);
    check("prst_busy0", BUSY, 1);
    for (int i = 1; i < 16; i++) begin
      step();
      if (i == 1) check("prst_one_cycle", PANEL_RESET, 0);
      check("prst_busy", BUSY, 1);
    end
    step();
    check("prst_ready", BUSY, 0);
    check("prst_no_xfer", got_q.size(), 0);
    check("prst_no_overrun", OVERRUN, 0);

    // Randomized stream against a queue reference model
    got_q.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rb  = 8'($urandom);
      rdc = 1'($urandom_range(0, 1));
      if (!rdc && (rb == 8'h01)) rdc = 1'b1;
      hp  = $urandom_range(2, 3);
      exp_q.push_back({rdc, rb});
      send_byte(rb, rdc, 8, hp, 1'b0);
    end
    rand_ready = 1'b0;
    BYTE_READY = 1'b1;
    repeat (6) step();
    exp_cnt = exp_q.size();
    check("rand_count", got_q.size(), exp_cnt);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("rand_byte", got_q.pop_front(), exp_q.pop_front());
    check("rand_no_overrun", OVERRUN, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
